// File: rtl/core_dbg_pkg.sv
// Shared debug types for the core: breakpoint modes, monitor FSM states, default widths.
package core_dbg_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    BP_OFF       = 2'b00,
    BP_DUMP      = 2'b01,
    BP_STOP      = 2'b10,
    BP_DUMP_STOP = 2'b11
  } bp_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD,
    XFER,
    STOPPED
  } mon_state_e;

endpackage

// File: rtl/bp_match_table.sv
// Breakpoint table with one write port and a combinational lowest-index-wins PC match.
// Writes land on the next edge, so a same-cycle match always sees the old contents.
module bp_match_table
  import core_dbg_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NUM_BP = 4,
  parameter int BP_IW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [BP_IW-1:0] wr_idx,
  input  logic [XLEN-1:0]  wr_addr,
  input  bp_mode_e         wr_mode,
  input  logic [XLEN-1:0]  pc,
  output logic             hit,
  output logic [BP_IW-1:0] hit_idx,
  output bp_mode_e         hit_mode
);

  logic [XLEN-1:0] addr_q [NUM_BP];
  bp_mode_e        mode_q [NUM_BP];

  // Indices with no matching entry simply select nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BP; i++) begin
        addr_q[i] <= '0;
        mode_q[i] <= BP_OFF;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr_idx == BP_IW'(i)) begin
          addr_q[i] <= wr_addr;
          mode_q[i] <= wr_mode;
        end
      end
    end
  end

  // Scan high-to-low so the lowest matching index is the last to assign.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_mode = BP_OFF;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if ((mode_q[i] != BP_OFF) && (addr_q[i] == pc)) begin
        hit      = 1'b1;
        hit_idx  = BP_IW'(i);
        hit_mode = mode_q[i];
      end
    end
  end

endmodule

// File: rtl/pc_break_monitor.sv
// PC breakpoint monitor: on a retired-PC hit it stalls the core and streams a header plus NREGS register words.
// Header 1 cycle after the hit, then one data beat per 2 cycles; each beat is held until dump_ready.
module pc_break_monitor
  import core_dbg_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NUM_BP = 4,
  parameter int NREGS  = NREGS_DEF,
  parameter int REG_AW = 5,
  parameter int BP_IW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bp_wr_en,
  input  logic [BP_IW-1:0]  bp_wr_idx,
  input  logic [XLEN-1:0]   bp_wr_addr,
  input  logic [1:0]        bp_wr_mode,
  input  logic              pc_valid,
  input  logic [XLEN-1:0]   pc,
  output logic              rf_rd_en,
  output logic [REG_AW-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]   rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [XLEN-1:0]   dump_data,
  output logic              dump_hdr,
  output logic [REG_AW-1:0] dump_idx,
  output logic              dump_last,
  output logic              core_stall,
  output logic              stop_req,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  logic             tbl_hit;
  logic [BP_IW-1:0] unused_hit_idx;
  bp_mode_e         tbl_mode;

  mon_state_e        state_q, state_d;
  logic [XLEN-1:0]   pc_q, data_q;
  bp_mode_e          mode_q;
  logic [REG_AW-1:0] idx_q;
  logic              hit, last_beat;

  bp_match_table #(
    .XLEN   (XLEN),
    .NUM_BP (NUM_BP),
    .BP_IW  (BP_IW)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bp_wr_en),
    .wr_idx   (bp_wr_idx),
    .wr_addr  (bp_wr_addr),
    .wr_mode  (bp_mode_e'(bp_wr_mode)),
    .pc       (pc),
    .hit      (tbl_hit),
    .hit_idx  (unused_hit_idx),
    .hit_mode (tbl_mode)
  );

  assign hit       = pc_valid & tbl_hit & (state_q == IDLE);
  assign last_beat = (idx_q == REG_AW'(NREGS - 1));

  always_comb begin
    state_d    = state_q;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    case (state_q)
      IDLE:    if (hit) state_d = (tbl_mode == BP_STOP) ? STOPPED : HDR;
      HDR:     if (dump_ready) begin
                 rf_rd_en = 1'b1;
                 state_d  = RD;
               end
      RD:      state_d = XFER;
      XFER:    if (dump_ready) begin
                 if (last_beat) begin
                   state_d = (mode_q == BP_DUMP_STOP) ? STOPPED : IDLE;
                 end else begin
                   rf_rd_en   = 1'b1;
                   rf_rd_addr = idx_q + REG_AW'(1);
                   state_d    = RD;
                 end
               end
      STOPPED: state_d = STOPPED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      mode_q   <= BP_OFF;
      idx_q    <= '0;
      data_q   <= '0;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (hit) begin
        pc_q   <= pc;
        mode_q <= tbl_mode;
        idx_q  <= '0;
      end
      if (state_q == RD) data_q <= rf_rd_data;
      if ((state_q == XFER) && dump_ready && !last_beat) idx_q <= idx_q + REG_AW'(1);
      // A retiring match the core pushed through despite the stall is counted, never serviced.
      if (pc_valid && tbl_hit && (state_q != IDLE) && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign dump_valid = (state_q == HDR) || (state_q == XFER);
  assign dump_hdr   = (state_q == HDR);
  assign dump_data  = (state_q == HDR) ? pc_q : ((state_q == XFER) ? data_q : '0);
  assign dump_idx   = (state_q == XFER) ? idx_q : '0;
  assign dump_last  = (state_q == XFER) && last_beat;
  assign busy       = (state_q != IDLE);
  assign stop_req   = (state_q == STOPPED);
  assign core_stall = hit | busy;

endmodule

// File: tb/tb_pc_break_monitor.sv
// Bench for pc_break_monitor: vector table, hand-written corner sequences and a randomized model check.
module tb_pc_break_monitor;

  localparam int XLEN = 32, NUM_BP = 4, NREGS = 32, REG_AW = 5, BP_IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              bp_wr_en;
  logic [BP_IW-1:0]  bp_wr_idx;
  logic [XLEN-1:0]   bp_wr_addr;
  logic [1:0]        bp_wr_mode;
  logic              pc_valid;
  logic [XLEN-1:0]   pc;
  logic              rf_rd_en;
  logic [REG_AW-1:0] rf_rd_addr;
  logic [XLEN-1:0]   rf_rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [XLEN-1:0]   dump_data;
  logic              dump_hdr;
  logic [REG_AW-1:0] dump_idx;
  logic              dump_last;
  logic              core_stall;
  logic              stop_req;
  logic              busy;
  logic [7:0]        drop_cnt;

  pc_break_monitor #(
    .XLEN(XLEN), .NUM_BP(NUM_BP), .NREGS(NREGS), .REG_AW(REG_AW), .BP_IW(BP_IW)
  ) dut (
    .clk(clk), .rst(rst),
    .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr), .bp_wr_mode(bp_wr_mode),
    .pc_valid(pc_valid), .pc(pc),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_hdr(dump_hdr), .dump_idx(dump_idx), .dump_last(dump_last),
    .core_stall(core_stall), .stop_req(stop_req), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Register file: read data appears the cycle after the request, junk otherwise.
  logic [XLEN-1:0] regs [NREGS];
  always @(posedge clk) rf_rd_data <= rf_rd_en ? regs[rf_rd_addr] : $urandom;

  typedef struct packed {
    logic              hdr;
    logic [REG_AW-1:0] idx;
    logic [XLEN-1:0]   data;
    logic              last;
  } beat_t;

  typedef struct {
    logic [1:0] a_idx; logic [31:0] a_addr; logic [1:0] a_mode;
    logic [1:0] b_idx; logic [31:0] b_addr; logic [1:0] b_mode;
    logic pv; logic [31:0] probe;
    logic exp_stall; logic exp_dump; logic exp_stop;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  beat_t got_q[$];
  beat_t prev_b;
  logic  hold_pend = 1'b0;
  logic  s_valid, s_acc, s_last, s_hdr, s_stall, s_stop, s_busy;
  logic [REG_AW-1:0] s_idx;
  logic [7:0] s_drop;

  // Reference model: breakpoint table contents and expected drop count.
  logic [31:0] m_addr [NUM_BP];
  logic [1:0]  m_mode [NUM_BP];
  int          exp_drop = 0;
  logic [31:0] pool [5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h8000_0100};

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic int lookup(input logic [31:0] p);
    for (int i = 0; i < NUM_BP; i++)
      if (m_mode[i] != 2'b00 && m_addr[i] == p) return i;
    return -1;
  endfunction

  task automatic note_drop(input logic [31:0] p);
    if (lookup(p) >= 0 && exp_drop < 255) exp_drop++;
  endtask

  task automatic step();
    beat_t b;
    @(negedge clk);
    b.hdr = dump_hdr; b.idx = dump_idx; b.data = dump_data; b.last = dump_last;
    if (hold_pend) check("hold_stable", 64'({dump_valid, b}), 64'({1'b1, prev_b}));
    hold_pend = dump_valid && !dump_ready;
    prev_b  = b;
    s_valid = dump_valid; s_acc = dump_valid && dump_ready; s_last = dump_last;
    s_idx   = dump_idx;   s_hdr = dump_hdr;  s_stall = core_stall;
    s_stop  = stop_req;   s_busy = busy;     s_drop = drop_cnt;
    if (s_acc) got_q.push_back(b);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bp_wr_en = 1'b0; pc_valid = 1'b0; dump_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < NUM_BP; i++) begin m_addr[i] = '0; m_mode[i] = 2'b00; end
    exp_drop = 0;
  endtask

  task automatic write_bp(input logic [1:0] idx, input logic [31:0] addr, input logic [1:0] mode);
    bp_wr_en = 1'b1; bp_wr_idx = idx; bp_wr_addr = addr; bp_wr_mode = mode;
    step();
    bp_wr_en = 1'b0;
    m_addr[idx] = addr; m_mode[idx] = mode;
  endtask

  task automatic hold_stopped(input string nm);
    int bad = 0;
    pc_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!(s_stop && s_stall && s_busy) || s_valid) bad++;
    end
    check(nm, 64'(bad), 64'd0);
  endtask

  // Called just after the hit cycle; runs the stream to its last beat and checks it.
  // rmode: 0 ready high, 1 ready 1-0-0-1, 2 random.
  task automatic run_dump(input string nm, input int rmode, input logic [31:0] hpc,
                          input logic exp_stop, input int drops, input logic rnd);
    beat_t exp_q[$];
    beat_t e;
    int cyc = 0;
    logic done = 1'b0;
    logic wr;
    logic [1:0] w_idx, w_mode;
    logic [31:0] w_addr;
    while (!done && cyc < 2000) begin
      case (rmode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      pc_valid = 1'b0;
      if (drops > 0 && cyc % 5 == 2) begin
        pc_valid = 1'b1;
        pc = rnd ? pool[$urandom_range(0, 4)] : 32'h174;
        drops--;
        note_drop(pc);
      end
      wr = rnd && ($urandom_range(0, 9) == 0);
      w_idx = 2'($urandom_range(0, 3)); w_addr = pool[$urandom_range(0, 4)]; w_mode = 2'($urandom_range(0, 3));
      bp_wr_en = wr; bp_wr_idx = w_idx; bp_wr_addr = w_addr; bp_wr_mode = w_mode;
      step();
      cyc++;
      if (wr) begin m_addr[w_idx] = w_addr; m_mode[w_idx] = w_mode; end
      if (s_acc && s_last) done = 1'b1;
    end
    bp_wr_en = 1'b0; pc_valid = 1'b0; dump_ready = 1'b1;
    check({nm, "_done"}, 64'(done), 64'd1);
    if (rmode == 0) check({nm, "_cycles"}, 64'(cyc), 64'(1 + 2 * NREGS));
    e.hdr = 1'b1; e.idx = '0; e.data = hpc; e.last = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < NREGS; i++) begin
      e.hdr = 1'b0; e.idx = REG_AW'(i); e.data = regs[i]; e.last = (i == NREGS - 1);
      exp_q.push_back(e);
    end
    check({nm, "_beats"}, 64'(got_q.size()), 64'(NREGS + 1));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
    step();
    check({nm, "_after"}, 64'({s_busy, s_stop, s_stall}), 64'({exp_stop, exp_stop, exp_stop}));
    if (exp_stop) hold_stopped({nm, "_stopped"});
  endtask

  vec_t vecs [12];
  initial begin
    vecs[0]  = '{2'd0, 32'h0FC, 2'b01, 2'd0, 32'h0FC, 2'b01, 1'b1, 32'h0FC, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{2'd0, 32'h0FC, 2'b01, 2'd0, 32'h0FC, 2'b01, 1'b1, 32'h0F8, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'd0, 32'h0FC, 2'b01, 2'd0, 32'h0FC, 2'b01, 1'b0, 32'h0FC, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'd1, 32'h328, 2'b11, 2'd3, 32'h328, 2'b10, 1'b1, 32'h328, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{2'd3, 32'h328, 2'b10, 2'd1, 32'h328, 2'b11, 1'b1, 32'h328, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{2'd2, 32'h33C, 2'b10, 2'd2, 32'h33C, 2'b10, 1'b1, 32'h33C, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{2'd0, 32'h100, 2'b00, 2'd1, 32'h100, 2'b10, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{2'd0, 32'h8000_0000, 2'b10, 2'd1, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'd0, 32'h8000_0000, 2'b10, 2'd1, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'd0, 32'h8000_0000, 2'b10, 2'd1, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{2'd0, 32'h200, 2'b01, 2'd0, 32'h204, 2'b10, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'd0, 32'h200, 2'b01, 2'd0, 32'h204, 2'b10, 1'b1, 32'h204, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; bp_wr_en = 1'b0; bp_wr_idx = '0; bp_wr_addr = '0; bp_wr_mode = '0;
    pc_valid = 1'b0; pc = '0; dump_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) regs[i] = 32'(i * 32'h11);

    step();
    check("reset_ctl", 64'({rf_rd_en, rf_rd_addr, dump_valid, dump_hdr, dump_idx, dump_last,
                            core_stall, stop_req, busy, drop_cnt}), 64'd0);
    check("reset_data", 64'(dump_data), 64'd0);
    do_reset();

    for (int v = 0; v < 12; v++) begin
      do_reset();
      write_bp(vecs[v].a_idx, vecs[v].a_addr, vecs[v].a_mode);
      write_bp(vecs[v].b_idx, vecs[v].b_addr, vecs[v].b_mode);
      got_q.delete();
      pc_valid = vecs[v].pv; pc = vecs[v].probe; dump_ready = 1'b1;
      step();
      pc_valid = 1'b0;
      check($sformatf("v%0d_stall", v), 64'(s_stall), 64'(vecs[v].exp_stall));
      check($sformatf("v%0d_hit_stop", v), 64'(s_stop), 64'd0);
      if (vecs[v].exp_dump) begin
        run_dump($sformatf("v%0d", v), 0, vecs[v].probe, vecs[v].exp_stop, 0, 1'b0);
      end else begin
        step();
        check($sformatf("v%0d_next", v), 64'({s_stop, s_busy, s_valid}),
              64'({vecs[v].exp_stop, vecs[v].exp_stop, 1'b0}));
        if (vecs[v].exp_stop) hold_stopped($sformatf("v%0d_stopped", v));
      end
    end

    // Ready toggling 1-0-0-1 with three drop pulses on another enabled PC.
    do_reset();
    write_bp(2'd0, 32'h0FC, 2'b01);
    write_bp(2'd1, 32'h174, 2'b01);
    got_q.delete();
    pc_valid = 1'b1; pc = 32'h0FC; step();
    run_dump("toggle", 1, 32'h0FC, 1'b0, 3, 1'b0);
    check("drop_cnt3", 64'(s_drop), 64'd3);

    // Asynchronous reset while holding the idx 10 data beat.
    got_q.delete();
    pc_valid = 1'b1; pc = 32'h0FC; dump_ready = 1'b1; step();
    pc_valid = 1'b0;
    for (int c = 0; c < 200 && got_q.size() < 11; c++) step();
    dump_ready = 1'b0;
    step(); step();
    check("pre_rst_beat", 64'({s_valid, s_hdr, s_idx}), 64'({1'b1, 1'b0, 5'd10}));
    #2 rst = 1'b1; hold_pend = 1'b0;
    #1;
    check("async_rst_ctl", 64'({rf_rd_en, rf_rd_addr, dump_valid, dump_hdr, dump_idx, dump_last,
                                core_stall, stop_req, busy, drop_cnt}), 64'd0);
    check("async_rst_data", 64'(dump_data), 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin m_addr[i] = '0; m_mode[i] = 2'b00; end
    exp_drop = 0;
    step();
    pc_valid = 1'b1; pc = 32'h0FC; step();
    pc_valid = 1'b0;
    check("post_rst_stall", 64'(s_stall), 64'd0);
    step();
    check("post_rst_busy", 64'({s_busy, s_valid}), 64'd0);

    // Stop-only entry, then drop counter saturation while stopped.
    do_reset();
    write_bp(2'd2, 32'h33C, 2'b10);
    pc_valid = 1'b1; pc = 32'h33C; step();
    check("stop_hit", 64'({s_stall, s_stop}), 64'({1'b1, 1'b0}));
    begin
      int bad = 0;
      for (int i = 0; i < 300; i++) begin
        note_drop(32'h33C);
        step();
        if (i == 0) check("stop_next_cycle", 64'(s_stop), 64'd1);
        if (s_valid) bad++;
      end
      check("stop_no_dump", 64'(bad), 64'd0);
    end
    pc_valid = 1'b0; step();
    check("drop_sat", 64'(s_drop), 64'd255);
    check("drop_model", 64'(s_drop), 64'(exp_drop));
    hold_stopped("stop_hold");
    do_reset();
    check("stop_cleared", 64'({s_stop, s_drop}), 64'd0);
    pc_valid = 1'b1; pc = 32'h33C; step();
    pc_valid = 1'b0;
    check("table_cleared", 64'(s_stall), 64'd0);

    // Randomized tables, probes, ready, drop pulses and concurrent table writes.
    for (int it = 0; it < 20; it++) begin
      logic [31:0] hpc;
      int k;
      do_reset();
      for (int r = 0; r < NREGS; r++) regs[r] = $urandom;
      for (int e = 0; e < NUM_BP; e++)
        write_bp(2'(e), pool[$urandom_range(0, 4)], 2'($urandom_range(0, 3)));
      hpc = pool[$urandom_range(0, 4)];
      k = lookup(hpc);
      got_q.delete();
      pc_valid = 1'b1; pc = hpc; dump_ready = 1'b1; step();
      pc_valid = 1'b0;
      check($sformatf("r%0d_stall", it), 64'(s_stall), 64'(k >= 0));
      if (k < 0) begin
        step();
        check($sformatf("r%0d_idle", it), 64'({s_busy, s_valid}), 64'd0);
      end else if (m_mode[k] == 2'b10) begin
        step();
        check($sformatf("r%0d_stop", it), 64'({s_stop, s_valid}), 64'({1'b1, 1'b0}));
      end else begin
        run_dump($sformatf("r%0d", it), 2, hpc, m_mode[k] == 2'b11, int'($urandom_range(0, 4)), 1'b1);
        check($sformatf("r%0d_drop", it), 64'(s_drop), 64'(exp_drop));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_break_monitor.md
Name: pc_break_monitor

Overview:
- Synthesizable, parametrised successor to the simulation-only PC-breakpoint dump logic in the core bench.
- Holds NUM_BP programmable PC breakpoints, each with a per-entry mode: disabled, dump, stop, or dump-then-stop.
- On a retired-PC hit it stalls the core, walks the register file through a dedicated read port, and streams a header beat plus NREGS words out over a valid/ready interface.
- Sits beside the core, fed by the write-back PC (pc_r2 stage) and a spare register-file read port.

Parameters:
XLEN, 32, data/PC width
NUM_BP, 4, number of breakpoint entries (1..16)
NREGS, 32, registers dumped per hit
REG_AW, 5, register index width, must satisfy 2**REG_AW >= NREGS
BP_IW, 2, breakpoint index width, must satisfy 2**BP_IW >= NUM_BP

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
bp_wr_en  in  1  write one breakpoint entry
bp_wr_idx  in  BP_IW  entry index; values >= NUM_BP ignored
bp_wr_addr  in  XLEN  breakpoint PC
bp_wr_mode  in  2  00 disabled, 01 dump, 10 stop, 11 dump-then-stop
pc_valid  in  1  pc is a retiring instruction this cycle
pc  in  XLEN  retiring PC
rf_rd_en  out  1  register-file read request
rf_rd_addr  out  REG_AW  register index
rf_rd_data  in  XLEN  read data, valid exactly 1 cycle after rf_rd_en
dump_valid  out  1  stream beat valid
dump_ready  in  1  sink accepts beat
dump_data  out  XLEN  header PC or register value
dump_hdr  out  1  beat is the header (data = hit PC)
dump_idx  out  REG_AW  register index of data beat (0 on header)
dump_last  out  1  final beat of a dump
core_stall  out  1  core must freeze retirement
stop_req  out  1  sticky stop request
busy  out  1  FSM not in IDLE
drop_cnt  out  8  saturating count of hits ignored while busy

Behaviour:
- Reset (async, rst=1): every table entry is disabled with addr 0. FSM goes to IDLE. All outputs are 0, including drop_cnt. Reset mid-dump aborts immediately; no dump_last is emitted.
- Match: hit = pc_valid & state==IDLE & some enabled entry with addr==pc. When several entries match, the lowest index wins. Matching uses the table contents from before any same-cycle write; a written entry takes effect next cycle.
- core_stall = hit | (state != IDLE). This is the only combinational path from pc; it guarantees the core holds its registers from the hit cycle onward.
- Hit with mode 10: stop_req <= 1 next cycle, FSM -> STOPPED. No dump is emitted.
- Hit with mode 01 or 11: latch the PC and mode, FSM -> HDR.
- HDR: dump_valid=1, dump_hdr=1, dump_data=latched PC, dump_idx=0, dump_last=0. Held until dump_ready. On the handshake, issue rf_rd_en with rf_rd_addr=0 and go to RD.
- RD (one cycle): capture rf_rd_data into the output register, go to XFER.
- XFER: dump_valid=1, dump_data=captured value, dump_idx=current index, dump_last=(idx==NREGS-1). All outputs are stable while dump_ready=0.
  - On handshake with idx<NREGS-1: increment idx, issue the next read, go to RD.
  - On handshake of the last beat: latched mode 11 -> STOPPED with stop_req<=1; latched mode 01 -> IDLE.
- Throughput: one data beat per 2 cycles minimum. The header is 1 cycle minimum. A full dump with dump_ready tied high takes 1+2*NREGS cycles.
- STOPPED: core_stall=1, busy=1, stop_req=1 until reset. No further hits or dumps.
- pc_valid asserted while busy (core ignored stall): the hit is not serviced; drop_cnt increments if the pc matches an enabled entry, saturating at 255.
- Table writes are accepted in every state, including during a dump and in STOPPED.
- Arithmetic: PC compare is full XLEN equality with no masking. idx is a REG_AW-bit counter; there is no wrap past NREGS-1.

Decomposition:
- Shared package (core_dbg_pkg): bp_mode_e enum (BP_OFF, BP_DUMP, BP_STOP, BP_DUMP_STOP), mon_state_e enum (IDLE, HDR, RD, XFER, STOPPED), and the default XLEN/NREGS constants shared with the core.
- One sub-module: bp_match_table. It holds the NUM_BP entries and the write port, and provides the priority-encoded hit, hit_idx, and hit_mode outputs.
- The FSM and stream logic live in the top module.

Test Plan:
- Entry0=0x00FC mode 01, regs x1..x31 preset to i*0x11, dump_ready=1, pc_valid with pc=0x00FC -> header beat data=0x000000FC, then 32 beats with x5=0x00000055, dump_last on idx 31, total 65 cycles, then IDLE with stall=0.
- Same dump with dump_ready toggled 1-0-0-1 per cycle -> no beat lost or duplicated, data held stable across stalls, order idx 0..31.
- Entry1=0x0328 mode 11 and entry3=0x0328 mode 10 -> entry1 wins; full dump, then stop_req=1 and core_stall=1 held for 100 cycles.
- Entry2=0x033C mode 10 -> stop_req=1 the cycle after the hit, no dump_valid ever; rst pulse clears stop_req and the table.
- pc_valid with pc=0x0174 (enabled) asserted 3 times during a dump -> drop_cnt=3, dump unaffected. Then 300 forced hits -> drop_cnt saturates at 255.
- Async rst asserted mid-XFER at idx 10 -> all outputs 0 immediately; after release, the same pc does not match because the table is cleared.
